hazard3_regfile_wb_arbiter: RTL and testbench



---
 rtl/hazard3_regfile_wb_arbiter.sv | 169 ++++++++++++++++
 tb/tb_hazard3_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard3_regfile_wb_arbiter.sv
// Regfile write-port arbiter: zero-fills the register file after reset, then
// merges unstallable ALU writebacks with FIFO-buffered load returns onto the
// single write port. Exposes a pending mask of registers with a queued load.
module hazard3_regfile_wb_arbiter #(
    parameter int N_REGS         = 16,
    parameter int W_DATA         = 32,
    parameter int W_ADDR         = 4,
    parameter int LD_FIFO_DEPTH  = 2,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_wen,
    input  logic [W_ADDR-1:0] alu_waddr,
    input  logic [W_DATA-1:0] alu_wdata,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [W_ADDR-1:0] ld_waddr,
    input  logic [W_DATA-1:0] ld_wdata,
    output logic              rf_wen,
    output logic [W_ADDR-1:0] rf_waddr,
    output logic [W_DATA-1:0] rf_wdata,
    output logic              init_done,
    output logic [N_REGS-1:0] pending_mask
);

    localparam int W_PTR = (LD_FIFO_DEPTH > 1) ? $clog2(LD_FIFO_DEPTH) : 1;
    localparam int W_CNT = $clog2(LD_FIFO_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Next FIFO pointer, wrapping modulo the FIFO depth
    function automatic logic [W_PTR-1:0] ptr_next(input logic [W_PTR-1:0] p);
        logic [W_PTR-1:0] n;
        if (p == W_PTR'(LD_FIFO_DEPTH - 1)) begin
            n = {W_PTR{1'b0}};
        end else begin
            n = p + {{(W_PTR-1){1'b0}}, 1'b1};
        end
        return n;
    endfunction

    state_t            r_state;
    logic [W_ADDR-1:0] r_clr_cnt;
    logic              r_init_done;
    logic              r_rf_wen;
    logic [W_ADDR-1:0] r_rf_waddr;
    logic [W_DATA-1:0] r_rf_wdata;

    logic [W_ADDR-1:0] r_fifo_addr [LD_FIFO_DEPTH];
    logic [W_DATA-1:0] r_fifo_data [LD_FIFO_DEPTH];
    logic              r_fifo_vld  [LD_FIFO_DEPTH];
    logic [W_PTR-1:0]  r_wr_ptr;
    logic [W_PTR-1:0]  r_rd_ptr;
    logic [W_CNT-1:0]  r_count;

    logic              w_run;
    logic              w_full;
    logic              w_ld_ready;
    logic              w_alu_go;
    logic              w_push;
    logic              w_pop;
    logic [N_REGS-1:0] w_mask;

    assign w_run      = (r_state == ST_RUN);
    assign w_full     = (r_count == W_CNT'(LD_FIFO_DEPTH));
    // Ready depends only on occupancy: a full FIFO never passes a load through
    assign w_ld_ready = w_run && !w_full;
    assign w_alu_go   = w_run && alu_wen && (alu_waddr != {W_ADDR{1'b0}});
    // x0 loads complete the handshake but are dropped here
    assign w_push     = ld_valid && w_ld_ready && (ld_waddr != {W_ADDR{1'b0}});
    assign w_pop      = w_run && !w_alu_go && (r_count != {W_CNT{1'b0}});

    // Decode every valid FIFO entry's destination into the pending mask
    always_comb begin
        w_mask = {N_REGS{1'b0}};
        for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
            w_mask = w_mask | (r_fifo_vld[i] ? (N_REGS'(1) << r_fifo_addr[i])
                                             : {N_REGS{1'b0}});
        end
    end

    // Load-return FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LD_FIFO_DEPTH; i++) begin
                r_fifo_addr[i] <= {W_ADDR{1'b0}};
                r_fifo_data[i] <= {W_DATA{1'b0}};
                r_fifo_vld[i]  <= 1'b0;
            end
            r_wr_ptr <= {W_PTR{1'b0}};
            r_rd_ptr <= {W_PTR{1'b0}};
            r_count  <= {W_CNT{1'b0}};
        end else begin
            if (w_pop) begin
                r_fifo_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr             <= ptr_next(r_rd_ptr);
            end
            if (w_push) begin
                r_fifo_addr[r_wr_ptr] <= ld_waddr;
                r_fifo_data[r_wr_ptr] <= ld_wdata;
                r_fifo_vld[r_wr_ptr]  <= 1'b1;
                r_wr_ptr              <= ptr_next(r_wr_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{(W_CNT-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(W_CNT-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear/run sequencing and the registered write-port decision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_init_done <= (CLEAR_ON_RESET == 0);
            r_clr_cnt   <= {W_ADDR{1'b0}};
            r_rf_wen    <= 1'b0;
            r_rf_waddr  <= {W_ADDR{1'b0}};
            r_rf_wdata  <= {W_DATA{1'b0}};
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_rf_wen   <= 1'b1;
                    r_rf_waddr <= r_clr_cnt;
                    r_rf_wdata <= {W_DATA{1'b0}};
                    r_clr_cnt  <= r_clr_cnt + {{(W_ADDR-1){1'b0}}, 1'b1};
                    if (r_clr_cnt == W_ADDR'(N_REGS - 1)) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end else begin
                        r_state     <= ST_CLEAR;
                        r_init_done <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_alu_go) begin
                        r_rf_wen   <= 1'b1;
                        r_rf_waddr <= alu_waddr;
                        r_rf_wdata <= alu_wdata;
                    end else if (w_pop) begin
                        r_rf_wen   <= 1'b1;
                        r_rf_waddr <= r_fifo_addr[r_rd_ptr];
                        r_rf_wdata <= r_fifo_data[r_rd_ptr];
                    end else begin
                        r_rf_wen   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_init_done <= 1'b1;
                    r_rf_wen    <= 1'b0;
                end
            endcase
        end
    end

    assign ld_ready     = w_ld_ready;
    assign rf_wen       = r_rf_wen;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign init_done    = r_init_done;
    assign pending_mask = w_mask;

endmodule

// File: tb/tb_hazard3_regfile_wb_arbiter.sv
// Directed bench for hazard3_regfile_wb_arbiter with a behavioural model
// feeding a scoreboard queue of expected regfile writes.
module tb_hazard3_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wen;
    logic [3:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_valid;
    logic        ld_ready;
    logic [3:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic        rf_wen;
    logic [3:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        init_done;
    logic [15:0] pending_mask;

    always #5 clk = ~clk;

    hazard3_regfile_wb_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .alu_wen      (alu_wen),
        .alu_waddr    (alu_waddr),
        .alu_wdata    (alu_wdata),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_waddr     (ld_waddr),
        .ld_wdata     (ld_wdata),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .init_done    (init_done),
        .pending_mask (pending_mask)
    );

    typedef struct packed {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t  exp_q [$];
    wr_t  mfifo [$];
    logic m_clear;
    logic m_init;
    int   m_cnt;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] m_mask();
        logic [15:0] m = 16'h0000;
        foreach (mfifo[i]) m[mfifo[i].a] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        mfifo.delete();
        m_clear = 1'b1;
        m_init  = 1'b0;
        m_cnt   = 0;
    endtask

    // One clock: pre-edge combinational checks and model step, then post-edge checks
    task automatic cycle();
        wr_t h;
        logic acc;
        #1;
        if (!rst) begin
            chk("ld_ready", ld_ready, (!m_clear && mfifo.size() < DEPTH));
            chk("pending_mask", pending_mask, m_mask());
            if (alu_wen) chk("alu_quiet_until_init", m_init, 1'b1);
            if (m_clear) begin
                exp_q.push_back({m_cnt[3:0], 32'h0000_0000});
                m_cnt++;
                if (m_cnt == 16) begin
                    m_clear = 1'b0;
                    m_init  = 1'b1;
                end
            end else begin
                acc = ld_valid && (mfifo.size() < DEPTH);
                if (alu_wen && alu_waddr != 4'd0) exp_q.push_back({alu_waddr, alu_wdata});
                else if (mfifo.size() > 0) exp_q.push_back(mfifo.pop_front());
                if (acc && ld_waddr != 4'd0) mfifo.push_back({ld_waddr, ld_wdata});
            end
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            h = exp_q.pop_front();
            chk("rf_wen", rf_wen, 1'b1);
            chk("rf_waddr", rf_waddr, h.a);
            chk("rf_wdata", rf_wdata, h.d);
        end else begin
            chk("rf_wen_idle", rf_wen, 1'b0);
        end
        chk("init_done", init_done, m_init);
    endtask

    initial begin
        rst = 1'b1; alu_wen = 1'b0; alu_waddr = 4'd0; alu_wdata = 32'd0;
        ld_valid = 1'b0; ld_waddr = 4'd0; ld_wdata = 32'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_wen", rf_wen, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 4'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        chk("rst_pending", pending_mask, 16'h0000);

        // 1: zero-fill; a load offered during clear must not be taken
        rst = 1'b0;
        ld_valid = 1'b1; ld_waddr = 4'd9; ld_wdata = 32'h99;
        repeat (16) cycle();
        ld_valid = 1'b0;
        chk("init_after_clear", init_done, 1'b1);
        chk("ready_after_clear", ld_ready, 1'b1);

        // 2: single ALU write, then idle holds address/data
        alu_wen = 1'b1; alu_waddr = 4'd5; alu_wdata = 32'hDEAD_BEEF;
        cycle();
        alu_wen = 1'b0;
        cycle();
        chk("idle_hold_waddr", rf_waddr, 4'd5);
        chk("idle_hold_wdata", rf_wdata, 32'hDEAD_BEEF);

        // 3: ALU busy for 4 cycles while loads queue up and fill the FIFO
        for (int k = 0; k < 4; k++) begin
            alu_wen   = 1'b1;
            alu_waddr = (k == 0) ? 4'd1 : (k == 1) ? 4'd2 : (k == 2) ? 4'd4 : 4'd6;
            alu_wdata = 32'hA0 + k;
            ld_valid  = 1'b1;
            ld_waddr  = (k == 0) ? 4'd3 : (k == 1) ? 4'd7 : 4'd9;
            ld_wdata  = (k == 0) ? 32'h11 : (k == 1) ? 32'h22 : 32'h33;
            if (k == 2) begin
                #1;
                chk("full_mask", pending_mask, 16'h0088);
                chk("full_ready", ld_ready, 1'b0);
            end
            cycle();
        end
        alu_wen = 1'b0;
        cycle();
        chk("mask_after_pop3", pending_mask, 16'h0080);
        cycle();
        ld_valid = 1'b0;
        cycle();
        cycle();

        // 4: x0 from both sources
        alu_wen = 1'b1; alu_waddr = 4'd0; alu_wdata = 32'h1234;
        ld_valid = 1'b1; ld_waddr = 4'd0; ld_wdata = 32'h55;
        cycle();
        chk("x0_mask", pending_mask, 16'h0000);
        chk("x0_ready", ld_ready, 1'b1);
        alu_wen = 1'b0; ld_valid = 1'b0;
        cycle();

        // 5: one entry resident, push and pop together for 8 cycles
        alu_wen = 1'b1; alu_waddr = 4'd8; alu_wdata = 32'h88;
        ld_valid = 1'b1; ld_waddr = 4'd10; ld_wdata = 32'h100;
        cycle();
        alu_wen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ld_waddr = 4'(i + 1);
            ld_wdata = 32'h200 + i;
            cycle();
        end
        ld_valid = 1'b0;
        cycle();
        cycle();

        // 6: reset while two loads are queued
        alu_wen = 1'b1; ld_valid = 1'b1;
        alu_waddr = 4'd11; alu_wdata = 32'hB1; ld_waddr = 4'd13; ld_wdata = 32'hD1;
        cycle();
        alu_waddr = 4'd12; alu_wdata = 32'hB2; ld_waddr = 4'd14; ld_wdata = 32'hD2;
        cycle();
        ld_valid = 1'b0; alu_waddr = 4'd15; alu_wdata = 32'hB3;
        cycle();
        alu_wen = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_wen", rf_wen, 1'b0);
        chk("async_rst_mask", pending_mask, 16'h0000);
        model_reset();
        cycle();
        rst = 1'b0;
        ld_valid = 1'b1; ld_waddr = 4'd6; ld_wdata = 32'h66;
        repeat (16) cycle();
        ld_valid = 1'b0;
        cycle();
        cycle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
